// File: rtl/heater_power_sequencer.sv
// Heater rod power sequencer: staggers rod turn-on, caps concurrent rods at
// MAX_ON, rotates rods round-robin when oversubscribed, and trips off on door open.
module heater_power_sequencer #(
  parameter int NUM_RODS    = 4,
  parameter int MAX_ON      = 2,
  parameter int STAGGER_CYC = 16,
  parameter int SLOT_CYC    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_RODS-1:0] rod_req,
  input  logic                door_open,
  output logic [NUM_RODS-1:0] rod_en,
  output logic [2:0]          on_cnt,
  output logic                ramping,
  output logic                tripped
);

  localparam int PW = (NUM_RODS > 1) ? $clog2(NUM_RODS) : 1;
  localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int LW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [SW-1:0] STAG_RELOAD = SW'(STAGGER_CYC - 1);
  localparam logic [LW-1:0] SLOT_RELOAD = LW'(SLOT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RAMP, STEADY, TRIP} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       rr_ptr, rr_ptr_n, eff_ptr, rot_ptr;
  logic [SW-1:0]       stagger_cnt, stagger_n;
  logic [LW-1:0]       slot_cnt, slot_n;
  logic [NUM_RODS-1:0] rod_en_n, tgt, kept, missing;
  logic                oversub;

  function automatic int popcount(input logic [NUM_RODS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < NUM_RODS; i++) if (v[i]) c++;
    return c;
  endfunction

  // First requested rod strictly after ptr, cyclic; ptr itself if it is the only one.
  function automatic logic [PW-1:0] next_req(input logic [NUM_RODS-1:0] req,
                                             input logic [PW-1:0] ptr);
    logic [PW-1:0] r;
    int idx;
    r = ptr;
    for (int k = NUM_RODS - 1; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_RODS;
      if (req[PW'(idx)]) r = PW'(idx);
    end
    return r;
  endfunction

  function automatic logic [NUM_RODS-1:0] target(input logic [NUM_RODS-1:0] req,
                                                 input logic [PW-1:0] ptr);
    logic [NUM_RODS-1:0] t;
    int idx;
    int c;
    t = '0;
    c = 0;
    for (int k = 0; k < NUM_RODS; k++) begin
      idx = (int'(ptr) + k) % NUM_RODS;
      if (req[PW'(idx)] && c < MAX_ON) begin
        t[PW'(idx)] = 1'b1;
        c++;
      end
    end
    return t;
  endfunction

  function automatic logic [NUM_RODS-1:0] first_cyc(input logic [NUM_RODS-1:0] mask,
                                                    input logic [PW-1:0] ptr);
    logic [NUM_RODS-1:0] o;
    int idx;
    o = '0;
    for (int k = NUM_RODS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_RODS;
      if (mask[PW'(idx)]) begin
        o = '0;
        o[PW'(idx)] = 1'b1;
      end
    end
    return o;
  endfunction

  always_comb begin
    // The pointer is re-anchored onto a requested rod before the window is formed.
    eff_ptr   = (rod_req[rr_ptr] || rod_req == '0) ? rr_ptr : next_req(rod_req, rr_ptr);
    tgt       = target(rod_req, eff_ptr);
    kept      = rod_en & tgt;
    missing   = tgt & ~kept;
    oversub   = popcount(rod_req) > MAX_ON;
    rot_ptr   = next_req(rod_req, eff_ptr);
    state_n   = state;
    rod_en_n  = kept;
    rr_ptr_n  = eff_ptr;
    stagger_n = stagger_cnt;
    slot_n    = slot_cnt;

    if (door_open) begin
      state_n  = TRIP;
      rod_en_n = '0;
    end else begin
      case (state)
        IDLE: begin
          rod_en_n = '0;
          if (rod_req != '0) begin
            state_n   = RAMP;
            stagger_n = '0;
          end
        end
        RAMP: begin
          if (rod_en == tgt) begin
            state_n = STEADY;
            slot_n  = SLOT_RELOAD;
          end else if (stagger_cnt == '0) begin
            rod_en_n  = kept | first_cyc(missing, eff_ptr);
            stagger_n = STAG_RELOAD;
          end else begin
            stagger_n = stagger_cnt - 1'b1;
          end
        end
        STEADY: begin
          if (rod_req == '0) begin
            state_n  = IDLE;
            rod_en_n = '0;
          end else if (oversub && slot_cnt == '0 && rod_en == tgt) begin
            // Swap-out and swap-in on one edge keeps the rod count flat.
            rr_ptr_n = rot_ptr;
            rod_en_n = target(rod_req, rot_ptr);
            slot_n   = SLOT_RELOAD;
          end else begin
            if (oversub && slot_cnt != '0) slot_n = slot_cnt - 1'b1;
            if (missing != '0) begin
              state_n   = RAMP;
              stagger_n = '0;
            end
          end
        end
        TRIP: begin
          rod_en_n = '0;
          if (rod_req != '0) begin
            state_n   = RAMP;
            stagger_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n  = IDLE;
          rod_en_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      stagger_cnt <= '0;
      slot_cnt    <= '0;
      rod_en      <= '0;
      on_cnt      <= '0;
      ramping     <= 1'b0;
      tripped     <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      stagger_cnt <= stagger_n;
      slot_cnt    <= slot_n;
      rod_en      <= rod_en_n;
      on_cnt      <= 3'(popcount(rod_en_n));
      ramping     <= (state_n == RAMP);
      tripped     <= (state_n == TRIP);
    end
  end

endmodule

// File: tb/tb_heater_power_sequencer.sv
// Bench for heater_power_sequencer: directed scenarios plus randomized request
// traffic, compared every cycle against a queue-based behavioural model.
module tb_heater_power_sequencer;

  localparam int MAX_ON = 2;
  localparam int STAG   = 16;
  localparam int SLOT   = 64;
  localparam int MI = 0, MR = 1, MS = 2, MT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       door_open = 1'b0;
  logic [3:0] rod_req = 4'b0000;
  logic [3:0] rod_en;
  logic [2:0] on_cnt;
  logic       ramping;
  logic       tripped;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int       m_mode = MI;
  bit [3:0] m_en   = 4'b0000;
  int       m_ptr  = 0;
  int       m_stag = 0;
  int       m_slot = 0;

  heater_power_sequencer #(
    .NUM_RODS(4), .MAX_ON(MAX_ON), .STAGGER_CYC(STAG), .SLOT_CYC(SLOT)
  ) dut (
    .clk(clk), .rst(rst), .rod_req(rod_req), .door_open(door_open),
    .rod_en(rod_en), .on_cnt(on_cnt), .ramping(ramping), .tripped(tripped)
  );

  always #5 clk = ~clk;

  function automatic int popc(input bit [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: requested rods listed in rotation order from the pointer; the
  // first MAX_ON of that list form the window that should be powered.
  task automatic model_step();
    int p;
    int ord[$];
    bit [3:0] tgt, kept, pick;
    if (rst) begin
      m_mode = MI; m_en = 4'b0000; m_ptr = 0; m_stag = 0; m_slot = 0;
      return;
    end
    p = m_ptr;
    if (rod_req != 4'b0000)
      for (int k = 3; k >= 0; k--) if (rod_req[2'((m_ptr + k) % 4)]) p = (m_ptr + k) % 4;
    ord = {};
    for (int k = 0; k < 4; k++) if (rod_req[2'((p + k) % 4)]) ord.push_back((p + k) % 4);
    tgt = 4'b0000;
    for (int i = 0; i < ord.size() && i < MAX_ON; i++) tgt[2'(ord[i])] = 1'b1;
    kept  = m_en & tgt;
    m_ptr = p;
    if (door_open) begin
      m_mode = MT; m_en = 4'b0000;
      return;
    end
    case (m_mode)
      MI: begin
        m_en = 4'b0000;
        if (rod_req != 4'b0000) begin m_mode = MR; m_stag = 0; end
      end
      MR: begin
        if (m_en == tgt) begin
          m_mode = MS; m_slot = SLOT - 1;
        end else if (m_stag == 0) begin
          pick = 4'b0000;
          foreach (ord[i])
            if (pick == 4'b0000 && tgt[2'(ord[i])] && !kept[2'(ord[i])]) pick[2'(ord[i])] = 1'b1;
          m_en = kept | pick; m_stag = STAG - 1;
        end else begin
          m_en = kept; m_stag--;
        end
      end
      MS: begin
        if (rod_req == 4'b0000) begin
          m_mode = MI; m_en = 4'b0000;
        end else if (ord.size() > MAX_ON && m_slot == 0 && m_en == tgt) begin
          m_en[2'(ord[0])] = 1'b0;
          m_en[2'(ord[MAX_ON])] = 1'b1;
          m_ptr  = ord[1];
          m_slot = SLOT - 1;
        end else begin
          if (ord.size() > MAX_ON && m_slot > 0) m_slot--;
          m_en = kept;
          if ((tgt & ~kept) != 4'b0000) begin m_mode = MR; m_stag = 0; end
        end
      end
      default: begin
        m_en = 4'b0000;
        if (rod_req != 4'b0000) begin m_mode = MR; m_stag = 0; end
        else m_mode = MI;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("m_rod_en", 8'(rod_en), 8'(m_en));
    check("m_on_cnt", 8'(on_cnt), 8'(popc(m_en)));
    check("m_ramping", 8'(ramping), 8'(m_mode == MR));
    check("m_tripped", 8'(tripped), 8'(m_mode == MT));
  endtask

  task automatic do_reset();
    rst = 1'b1; rod_req = 4'b0000; door_open = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int dur;
    // T1: reset state, then reset mid-RAMP
    do_reset();
    check("rst_rod_en", 8'(rod_en), 8'h00);
    check("rst_on_cnt", 8'(on_cnt), 8'h00);
    rod_req = 4'b0011;
    tick(); tick(); tick();
    check("t1_pre_en", 8'(rod_en), 8'h01);
    rst = 1'b1;
    tick(); tick();
    check("t1_rod_en", 8'(rod_en), 8'h00);
    check("t1_on_cnt", 8'(on_cnt), 8'h00);
    check("t1_ramping", 8'(ramping), 8'h00);
    rst = 1'b0; rod_req = 4'b0000;
    tick();
    check("t1_idle", 8'({ramping, tripped, rod_en}), 8'h00);

    // T2: stagger timing
    rod_req = 4'b0110;
    tick();
    check("t2_ramp_n", 8'(ramping), 8'h01);
    tick();
    check("t2_en_n1", 8'(rod_en), 8'h02);
    for (int i = 0; i < 16; i++) tick();
    check("t2_en_n17", 8'(rod_en), 8'h06);
    tick();
    check("t2_steady", 8'(ramping), 8'h00);

    // T5: drop a rod, then all
    rod_req = 4'b0100;
    tick();
    check("t5_drop", 8'(rod_en), 8'h04);
    rod_req = 4'b0000;
    tick();
    check("t5_idle", 8'(rod_en), 8'h00);

    // T3: oversubscribed rotation
    do_reset();
    rod_req = 4'b1111;
    tick(); tick();
    for (int i = 0; i < 16; i++) tick();
    check("t3_ramped", 8'(rod_en), 8'h03);
    for (int i = 0; i < 65; i++) begin tick(); check("t3_on_cnt", 8'(on_cnt), 8'h02); end
    check("t3_rot1", 8'(rod_en), 8'h06);
    for (int i = 0; i < 64; i++) begin tick(); check("t3_on_cnt", 8'(on_cnt), 8'h02); end
    check("t3_rot2", 8'(rod_en), 8'h0c);
    for (int i = 0; i < 64; i++) begin tick(); check("t3_on_cnt", 8'(on_cnt), 8'h02); end
    check("t3_rot3", 8'(rod_en), 8'h09);

    // T4: door interlock during STEADY
    door_open = 1'b1;
    tick();
    check("t4_trip_en", 8'(rod_en), 8'h00);
    check("t4_tripped", 8'(tripped), 8'h01);
    tick();
    door_open = 1'b0;
    tick();
    check("t4_reramp", 8'(ramping), 8'h01);
    check("t4_untrip", 8'(tripped), 8'h00);
    tick();
    check("t4_first", 8'(rod_en), 8'h08);

    // T6: request and door open on the same edge
    do_reset();
    rod_req = 4'b0001; door_open = 1'b1;
    tick();
    check("t6_tripped", 8'(tripped), 8'h01);
    for (int i = 0; i < 3; i++) begin tick(); check("t6_no_en", 8'(rod_en), 8'h00); end
    door_open = 1'b0; rod_req = 4'b0000;
    tick();
    check("t6_idle", 8'(tripped), 8'h00);

    // Randomized traffic against the model
    for (int s = 0; s < 150; s++) begin
      rod_req   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rod_req = 4'b1111;
      door_open = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 29) == 0);
      dur = rst ? 1 : (door_open ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 150)));
      for (int c = 0; c < dur; c++) tick();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
